odd_parity_checker: RTL
=======================

Name: odd_parity_checker

Overview:
- Receive side of the ASCII odd-parity character link.
- Accepts a stream of ASCII '0'/'1' characters framed as DATA_BITS data characters followed by one parity character.
- Checks that the frame contains an odd number of '1' characters, forwards the data characters, strips the parity character, and reports per-frame pass/fail plus a saturating error count.
- Sits between the link input and downstream character consumers.

Parameters:
DATA_BITS, 3, data characters per frame (legal range 1..255); the parity character follows them
CNT_W, 8, width of the internal position counter and of err_count

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset; clears all state and outputs immediately
in_valid  input  1  in carries a character this cycle
in  input  8 [8:1]  ASCII character: "0" (8'h30), "1" (8'h31), anything else illegal
out_valid  output  1  out carries a forwarded data character
out  output  8 [8:1]  registered copy of the accepted data character
frame_done  output  1  one-cycle pulse: a complete frame (data + parity) was checked
parity_ok  output  1  one-cycle pulse with frame_done when the total '1' count is odd
parity_err  output  1  one-cycle pulse with frame_done when the total '1' count is even
sym_err  output  1  one-cycle pulse: illegal character received, frame aborted
err_count  output  CNT_W  saturating count of parity_err plus sym_err events

Behaviour:
- Reset (asynchronous, active-high) sets:
  - out_valid, frame_done, parity_ok, parity_err and sym_err to 0.
  - out to 8'h00 and err_count to 0.
  - state to S_DATA, pos to 0 and ones_par to 0.
- All outputs are registered. Response appears the cycle after the accepting edge (latency 1).
- Cycles with in_valid=0 change no state. All pulse outputs and out_valid are 0 in the following cycle; out holds its last value.
- ones_par is a 1-bit running XOR: it toggles on each accepted "1".
- State S_DATA (expect data character, pos = characters accepted so far):
  - "1" or "0": set out=in and out_valid=1, update ones_par, increment pos. When pos reaches DATA_BITS, go to S_PAR with pos cleared.
  - Illegal character: pulse sym_err, increment err_count, clear pos and ones_par, stay in S_DATA (the next character starts a new frame). out_valid=0.
- State S_PAR (expect parity character):
  - "1" or "0": compute final = ones_par XOR (in=="1"). Pulse frame_done. Pulse parity_ok if final=1, else pulse parity_err and increment err_count. Clear ones_par, return to S_DATA. The parity character is not forwarded (out_valid=0).
  - Illegal character: pulse sym_err, increment err_count, no frame_done, clear ones_par, return to S_DATA.
- err_count saturates at 2^CNT_W-1. It never wraps.
- frame_done/parity_ok/parity_err are mutually exclusive with sym_err. parity_ok and parity_err are never both 1.
- Reset mid-frame discards the partial frame and produces no pulses. The first valid character after reset is data position 0.
- The frame format is exactly what the odd parity generator emits with its space replaced by the parity character. A frame whose data contains zero "1"s must carry parity "1".

Test Plan:
- Reset, then frame "1","0","1" + parity "1" (three ones total) -> out_valid high 3 cycles with out=31,30,31, then frame_done=1 and parity_ok=1 for one cycle; err_count=0.
- Frame "0","0","0" + parity "0" -> frame_done=1, parity_err=1, err_count=1. Then frame "0","0","0" + parity "1" -> parity_ok=1, err_count stays 1.
- Frame "1","1","x" -> sym_err pulse on the cycle after "x", err_count=1. The following "1","0","0" + "0" is treated as a fresh frame -> parity_ok=1.
- Insert in_valid=0 bubbles between every character of frame "1","1","0" + "1" -> same result as back-to-back (parity_ok=1). No outputs asserted during bubble cycles.
- 300 consecutive bad frames "0","0","0","0" -> err_count increments to 255 and stays 255; parity_err still pulses each frame.
- Assert reset asynchronously mid-clock after 2 data characters -> all outputs 0 before the next edge. The next frame "1","0","0" + "0" yields parity_ok=1.

Source files
------------

// File: rtl/odd_parity_checker.sv
// odd_parity_checker
//   Receive side of the ASCII odd-parity character link. Each frame is
//   DATA_BITS data characters ("0"/"1") followed by one parity character.
//   Data characters are forwarded. The parity character is checked and then
//   dropped. Each frame reports pass/fail, and a saturating error count is
//   kept.
//
// Ports
//   clk         system clock, rising-edge
//   reset       asynchronous active-high reset, clears all state and outputs
//   in_valid    in carries a character this cycle
//   in[8:1]     ASCII character, "0" (8'h30) or "1" (8'h31), others illegal
//   out_valid   out carries a forwarded data character
//   out[8:1]    registered copy of the last accepted data character
//   frame_done  pulse: complete frame (data + parity) checked
//   parity_ok   pulse with frame_done: total "1" count odd
//   parity_err  pulse with frame_done: total "1" count even
//   sym_err     pulse: illegal character, frame aborted
//   err_count   saturating count of parity_err + sym_err events
module odd_parity_checker #(
  parameter int DATA_BITS = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [8:1]       in,
  output logic             out_valid,
  output logic [8:1]       out,
  output logic             frame_done,
  output logic             parity_ok,
  output logic             parity_err,
  output logic             sym_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [8:1]       CH_ZERO  = 8'h30;
  localparam logic [8:1]       CH_ONE   = 8'h31;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA_BITS - 1);

  typedef enum logic {S_DATA, S_PAR} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] pos;
  logic             ones_par;

  logic             is_one_p0;
  logic             is_legal_p0;

  logic             vld_p1;
  logic [8:1]       data_p1;
  logic             done_p1;
  logic             ok_p1;
  logic             perr_p1;
  logic             sym_p1;
  logic [CNT_W-1:0] errcnt_p1;

  // ---- stage p0: character decode ----
  assign is_one_p0   = (in == CH_ONE);
  assign is_legal_p0 = (in == CH_ONE) || (in == CH_ZERO);

  // ---- stage p0 -> p1: frame tracking and registered outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_DATA;
      pos       <= '0;
      ones_par  <= 1'b0;
      vld_p1    <= 1'b0;
      data_p1   <= 8'h00;
      done_p1   <= 1'b0;
      ok_p1     <= 1'b0;
      perr_p1   <= 1'b0;
      sym_p1    <= 1'b0;
      errcnt_p1 <= '0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      ok_p1   <= 1'b0;
      perr_p1 <= 1'b0;
      sym_p1  <= 1'b0;
      if (in_valid) begin
        unique case (state)
          S_DATA: begin
            if (is_legal_p0) begin
              vld_p1   <= 1'b1;
              data_p1  <= in;
              ones_par <= ones_par ^ is_one_p0;
              if (pos == LAST_POS) begin
                state <= S_PAR;
                pos   <= '0;
              end else begin
                pos <= pos + CNT_W'(1);
              end
            end else begin
              sym_p1    <= 1'b1;
              errcnt_p1 <= sat_inc(errcnt_p1);
              pos       <= '0;
              ones_par  <= 1'b0;
            end
          end
          S_PAR: begin
            if (is_legal_p0) begin
              done_p1 <= 1'b1;
              if (ones_par ^ is_one_p0) begin
                ok_p1 <= 1'b1;
              end else begin
                perr_p1   <= 1'b1;
                errcnt_p1 <= sat_inc(errcnt_p1);
              end
            end else begin
              sym_p1    <= 1'b1;
              errcnt_p1 <= sat_inc(errcnt_p1);
            end
            ones_par <= 1'b0;
            state    <= S_DATA;
          end
          default: state <= S_DATA;
        endcase
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out        = data_p1;
  assign frame_done = done_p1;
  assign parity_ok  = ok_p1;
  assign parity_err = perr_p1;
  assign sym_err    = sym_p1;
  assign err_count  = errcnt_p1;

endmodule
